// File: rtl/coreir_slice_pack.sv
// coreir_slice_pack: extracts the bit field [hi-1:lo] from each accepted input
// beat and packs `lanes` consecutive fields into one output word (lane 0 in the
// least significant slice). A packet end (in_last) flushes a partial word;
// lanes that were never written read as zero. The output is a single register
// stage with valid/ready handshake and full one-word-per-cycle throughput.
module coreir_slice_pack #(
    parameter int width = 16,
    parameter int hi    = 16,
    parameter int lo    = 12,
    parameter int lanes = 4,
    localparam int SW   = hi - lo,
    localparam int OW   = lanes * SW,
    localparam int CW   = $clog2(lanes + 1),
    localparam int CNTW = (lanes > 1) ? $clog2(lanes) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_last
);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OW-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic            out_last_q, out_last_d;

    logic [SW-1:0]   slice_s;
    logic [OW-1:0]   merged_s;
    logic            accept_s;
    logic            complete_s;
    logic            unused_in_bits_s;

    // Only the selected field is ever looked at; the rest of the word is ignored.
    assign slice_s          = in_data[hi-1:lo];
    assign unused_in_bits_s = ^in_data;

    // The output stage can take a new word when empty or when it drains this cycle.
    assign in_ready   = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign complete_s = accept_s && ((cnt_q == CNTW'(lanes - 1)) || in_last);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

    // Accumulator with the incoming slice written into the current lane.
    always_comb begin
        merged_s = acc_q;
        for (int i = 0; i < lanes; i++) begin
            if (cnt_q == CNTW'(i)) begin
                merged_s[i*SW +: SW] = slice_s;
            end else begin
                merged_s[i*SW +: SW] = acc_q[i*SW +: SW];
            end
        end
    end

    // Next-state for the packing accumulator, lane counter and output register.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        if (complete_s) begin
            out_valid_d = 1'b1;
            out_data_d  = merged_s;
            out_count_d = CW'(cnt_q) + CW'(1);
            out_last_d  = in_last;
            acc_d       = {OW{1'b0}};
            cnt_d       = {CNTW{1'b0}};
        end else if (accept_s) begin
            acc_d = merged_s;
            cnt_d = cnt_q + CNTW'(1);
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that discards any partial or stalled word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CNTW{1'b0}};
            acc_q       <= {OW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {OW{1'b0}};
            out_count_q <= {CW{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
